pipelined_flag_alu: RTL

//  Parametrised, registered successor to the single-cycle IITB ALU. Owns the C/Z flag registers

---
 rtl/pipelined_flag_alu_if.sv | 27 ++
 rtl/pipelined_flag_alu.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipelined_flag_alu_if.sv
// pipelined_flag_alu_if: operand/result handshake bundle between decode, ALU and writeback
interface pipelined_flag_alu_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [1:0]       cz;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wr_en;
    logic             c_flag;
    logic             z_flag;
    logic             busy;
    modport master (
        output flush, in_valid, opcode, cz, a, b, out_ready,
        input  in_ready, out_valid, result, wr_en, c_flag, z_flag, busy
    );
    modport slave (
        input  flush, in_valid, opcode, cz, a, b, out_ready,
        output in_ready, out_valid, result, wr_en, c_flag, z_flag, busy
    );
endinterface

// File: rtl/pipelined_flag_alu.sv
// pipelined_flag_alu: registered flag-owning ALU with valid/ready handshakes; ALU_MUL_EN adds a shift-add multiplier FSM
module pipelined_flag_alu #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pipelined_flag_alu_if.slave bus
);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, MUL} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, res_q, res_d, nand_ab;
    logic               ov_q, wr_q, c_q, z_q, wr_d, c_d, z_d;
    logic               ready, accept, is_mul, cond_ok;
    logic [WIDTH:0]     sum, adl;
    assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign adl     = {1'b0, bus.a} + {1'b0, bus.b[WIDTH-2:0], 1'b0};
    assign nand_ab = ~(bus.a & bus.b);
    assign ready   = (state_q == IDLE) & (~ov_q | bus.out_ready) & ~bus.flush;
    assign accept  = bus.in_valid & ready;
    assign is_mul  = MUL_EN & (bus.opcode == 4'b1110);
    assign cond_ok = bus.cz == 2'b01 ? z_q : bus.cz == 2'b10 ? c_q : 1'b1;
    assign prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign bus.in_ready  = ready;
    assign bus.out_valid = ov_q;
    assign bus.result    = res_q;
    assign bus.wr_en     = wr_q;
    assign bus.c_flag    = c_q;
    assign bus.z_flag    = z_q;
    assign bus.busy      = MUL_EN & (state_q == MUL);
    // Single-cycle decode: next result, write qualifier and flags from operands and committed flags
    always_comb begin
        res_d = sum[WIDTH-1:0];
        wr_d  = 1'b1;
        c_d   = c_q;
        z_d   = z_q;
        case (bus.opcode)
            4'b0000: begin
                c_d = sum[WIDTH];
                z_d = ~|sum[WIDTH-1:0];
            end
            4'b0001: begin
                if (!cond_ok) begin
                    res_d = '0;
                    wr_d  = 1'b0;
                end else if (bus.cz == 2'b11) begin
                    res_d = adl[WIDTH-1:0];
                    c_d   = adl[WIDTH];
                    z_d   = ~|adl[WIDTH-1:0];
                end else begin
                    c_d = sum[WIDTH];
                    z_d = ~|sum[WIDTH-1:0];
                end
            end
            4'b0010: begin
                if (!cond_ok || bus.cz == 2'b11) begin
                    res_d = '0;
                    wr_d  = 1'b0;
                end else begin
                    res_d = nand_ab;
                    z_d   = ~|nand_ab;
                end
            end
            4'b1000: begin
                res_d = bus.a - bus.b;
                z_d   = bus.a == bus.b;
            end
            default: ;
        endcase
    end
    // Result/flag registers and multiplier FSM; flush aborts work but never touches flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            ov_q     <= 1'b0;
            wr_q     <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (accept && is_mul) begin
            state_q  <= MUL;
            cnt_q    <= CW'(WIDTH - 1);
            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
            mplier_q <= bus.b;
            prod_q   <= '0;
            ov_q     <= 1'b0;
        end else if (accept) begin
            res_q <= res_d;
            wr_q  <= wr_d;
            c_q   <= c_d;
            z_q   <= z_d;
            ov_q  <= 1'b1;
        end else if (state_q == MUL) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_q <= IDLE;
                res_q   <= prod_d[WIDTH-1:0];
                wr_q    <= 1'b1;
                c_q     <= |prod_d[2*WIDTH-1:WIDTH];
                z_q     <= ~|prod_d[WIDTH-1:0];
                ov_q    <= 1'b1;
            end
        end else if (bus.out_ready) begin
            ov_q <= 1'b0;
        end
    end
endmodule
